// File: rtl/sega_joy_pkg.sv
// Shared constants and types for the Sega controller reader: poll phases, pin and button
// bit positions, and the per-phase capture action handed to each port decoder.
package sega_joy_pkg;

  localparam int unsigned PH_SEL0  = 0;
  localparam int unsigned PH_SEL1  = 1;
  localparam int unsigned PH_DIR   = 2;
  localparam int unsigned PH_START = 3;
  localparam int unsigned PH_SEL4  = 4;
  localparam int unsigned PH_DET   = 5;
  localparam int unsigned PH_SIX   = 6;

  // Raw pin layout {p9,p6,right,left,down,up}
  localparam int unsigned PIN_U  = 0;
  localparam int unsigned PIN_D  = 1;
  localparam int unsigned PIN_L  = 2;
  localparam int unsigned PIN_R  = 3;
  localparam int unsigned PIN_P6 = 4;
  localparam int unsigned PIN_P9 = 5;

  // Button word layout {M,X,Y,Z,S,A,C,B,R,L,D,U}
  localparam int unsigned BIT_U = 0;
  localparam int unsigned BIT_D = 1;
  localparam int unsigned BIT_L = 2;
  localparam int unsigned BIT_R = 3;
  localparam int unsigned BIT_B = 4;
  localparam int unsigned BIT_C = 5;
  localparam int unsigned BIT_A = 6;
  localparam int unsigned BIT_S = 7;
  localparam int unsigned BIT_Z = 8;
  localparam int unsigned BIT_Y = 9;
  localparam int unsigned BIT_X = 10;
  localparam int unsigned BIT_M = 11;

  localparam logic [11:0] JOY_RELEASED = 12'hFFF;

  typedef enum logic [2:0] {
    ActNone,
    ActDir,
    ActStart,
    ActDetect,
    ActSix
  } act_e;

  function automatic logic dirs_low(logic [5:0] pins);
    return pins[PIN_R:PIN_U] == 4'b0000;
  endfunction

endpackage

// File: rtl/sega_joy_reader_if.sv
// One controller port as seen by the reader: synchronised pins in, decoded buttons out.
interface sega_joy_reader_if;
  logic [5:0]  pins;
  logic [11:0] joy;
  logic        six;

  modport master (input pins, output joy, output six);
  modport slave  (output pins, input joy, input six);
endinterface

// File: rtl/joy_sync.sv
// Two-flop synchroniser for the asynchronous controller pins; idles high like released pins.
module joy_sync #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);
  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/sega_joy_reader_port.sv
// Per-port decoder: folds the pin captures of each poll phase into the 12-bit button word.
module sega_joy_reader_port
  import sega_joy_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  act_e                act,
  sega_joy_reader_if.master   bus
);
  logic [11:0] joy_q, joy_d;
  logic        six_q, six_d;

  always_comb begin
    joy_d = joy_q;
    six_d = six_q;
    unique case (act)
      ActDir: begin
        joy_d[BIT_U] = bus.pins[PIN_U];
        joy_d[BIT_D] = bus.pins[PIN_D];
        joy_d[BIT_L] = bus.pins[PIN_L];
        joy_d[BIT_R] = bus.pins[PIN_R];
        joy_d[BIT_B] = bus.pins[PIN_P6];
        joy_d[BIT_C] = bus.pins[PIN_P9];
        six_d        = 1'b0;
      end
      ActStart: begin
        // A Mega Drive pad grounds left and right while select is low.
        if (!bus.pins[PIN_R] && !bus.pins[PIN_L]) begin
          joy_d[BIT_A] = bus.pins[PIN_P6];
          joy_d[BIT_S] = bus.pins[PIN_P9];
        end else begin
          joy_d[BIT_B] = bus.pins[PIN_P6];
          joy_d[BIT_C] = bus.pins[PIN_P9];
          joy_d[BIT_A] = 1'b1;
          joy_d[BIT_S] = 1'b1;
        end
      end
      ActDetect: begin
        if (dirs_low(bus.pins)) six_d = 1'b1;
      end
      ActSix: begin
        if (six_q) begin
          joy_d[BIT_Z] = bus.pins[PIN_U];
          joy_d[BIT_Y] = bus.pins[PIN_D];
          joy_d[BIT_X] = bus.pins[PIN_L];
          joy_d[BIT_M] = bus.pins[PIN_R];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_q <= JOY_RELEASED;
      six_q <= 1'b0;
    end else begin
      joy_q <= joy_d;
      six_q <= six_d;
    end
  end

  assign bus.joy = joy_q;
  assign bus.six = six_q;
endmodule

// File: rtl/sega_joy_reader.sv
// Polls two Sega controller ports once per 2^PHASE_W ticks by sequencing the shared select
// line, and decodes 3-button, 6-button and Master System pads on each port independently.
module sega_joy_reader
  import sega_joy_pkg::*;
#(
  parameter int unsigned PHASE_W = 8
) (
  input  logic        clk_sys,
  input  logic        res_n_i,
  input  logic        tick_i,
  input  logic [5:0]  joy1_pins_i,
  input  logic [5:0]  joy2_pins_i,
  output logic        joy_sel_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               sel_q, sel_d;
  logic               frame_q, frame_d;
  logic [11:0]        pins;
  act_e               act;

  sega_joy_reader_if port1_if ();
  sega_joy_reader_if port2_if ();

  joy_sync #(
    .Width(12)
  ) u_sync (
    .clk  (clk_sys),
    .rst_n(res_n_i),
    .d    ({joy2_pins_i, joy1_pins_i}),
    .q    (pins)
  );

  assign port1_if.pins = pins[5:0];
  assign port2_if.pins = pins[11:6];

  always_comb begin
    phase_d = phase_q;
    sel_d   = sel_q;
    frame_d = 1'b0;
    act     = ActNone;
    if (tick_i) begin
      phase_d = phase_q + PHASE_W'(1);
      unique case (phase_q)
        PHASE_W'(PH_SEL0):  sel_d = 1'b0;
        PHASE_W'(PH_SEL1):  sel_d = 1'b1;
        PHASE_W'(PH_DIR):   begin act = ActDir;    sel_d = 1'b0; end
        PHASE_W'(PH_START): begin act = ActStart;  sel_d = 1'b1; end
        PHASE_W'(PH_SEL4):  sel_d = 1'b0;
        PHASE_W'(PH_DET):   begin act = ActDetect; sel_d = 1'b1; end
        PHASE_W'(PH_SIX):   begin act = ActSix;    sel_d = 1'b0; frame_d = 1'b1; end
        // Long select-high idle lets a 6-button pad's internal counter time out.
        default:            sel_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      phase_q <= '0;
      sel_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  sega_joy_reader_port u_port1 (
    .clk  (clk_sys),
    .rst_n(res_n_i),
    .act  (act),
    .bus  (port1_if)
  );

  sega_joy_reader_port u_port2 (
    .clk  (clk_sys),
    .rst_n(res_n_i),
    .act  (act),
    .bus  (port2_if)
  );

  assign joy_sel_o = sel_q;
  assign frame_o   = frame_q;
  assign joy1_o    = port1_if.joy;
  assign joy2_o    = port2_if.joy;
  assign six1_o    = port1_if.six;
  assign six2_o    = port2_if.six;
endmodule

// File: tb/tb_sega_joy_reader.sv
// Bench for sega_joy_reader: behavioural pad models on both ports, a vector table scored
// on frame_o, and hand-written sequences for reset, stalled ticks and frame timing.
module tb_sega_joy_reader;

  typedef enum int {PadNone, PadMs, PadMd3, PadMd6} pad_e;

  // Buttons are given pressed-high in output bit order {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  typedef struct {
    pad_e        t1;
    logic [11:0] b1;
    pad_e        t2;
    logic [11:0] b2;
    logic [11:0] e1;
    logic [11:0] e2;
    logic        s1;
    logic        s2;
  } vec_t;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic tick = 1'b0;
  logic joy_sel, frame;
  logic pad_rst = 1'b1;

  pad_e        cfg1 = PadNone, cfg2 = PadNone;
  logic [11:0] btn1 = '0, btn2 = '0;

  int n_checks = 0;
  int n_errors = 0;
  vec_t exp_q[$];
  vec_t vecs[7];

  sega_joy_reader_if p1_if ();
  sega_joy_reader_if p2_if ();

  sega_joy_reader dut (
    .clk_sys    (clk),
    .res_n_i    (res_n),
    .tick_i     (tick),
    .joy1_pins_i(p1_if.pins),
    .joy2_pins_i(p2_if.pins),
    .joy_sel_o  (joy_sel),
    .joy1_o     (p1_if.joy),
    .joy2_o     (p2_if.joy),
    .six1_o     (p1_if.six),
    .six2_o     (p2_if.six),
    .frame_o    (frame)
  );

  always #5 clk = ~clk;

  // 6-button pad counter: counts select falls, cleared after a long select-high idle.
  logic sel_prev = 1'b1;
  int   idle = 0;
  int   lows = 0;
  always @(posedge clk) begin
    sel_prev <= joy_sel;
    if (pad_rst) begin
      lows <= 0;
      idle <= 0;
    end else begin
      idle <= joy_sel ? idle + 1 : 0;
      if (joy_sel && idle > 200) lows <= 0;
      else if (sel_prev && !joy_sel) lows <= lows + 1;
    end
  end

  function automatic logic [5:0] pad_pins(pad_e t, logic [11:0] b, logic sel, int cnt);
    logic [11:0] n;
    n = ~b;
    if (t == PadNone) return 6'h3F;
    if (t == PadMs) return {n[5], n[4], n[3:0]};
    if (t == PadMd6 && cnt == 3)
      return sel ? {n[5], n[4], n[11], n[10], n[9], n[8]} : {n[7], n[6], 4'b0000};
    if (t == PadMd6 && cnt == 4 && !sel) return {n[7], n[6], 4'b1111};
    return sel ? {n[5], n[4], n[3:0]} : {n[7], n[6], 2'b00, n[1:0]};
  endfunction

  assign p1_if.pins = pad_pins(cfg1, btn1, joy_sel, lows);
  assign p2_if.pins = pad_pins(cfg2, btn2, joy_sel, lows);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each completed frame is scored against the oldest pending expectation.
  always @(negedge clk) begin
    if (frame && exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      check("sb_joy1", 32'(p1_if.joy), 32'(e.e1));
      check("sb_joy2", 32'(p2_if.joy), 32'(e.e2));
      check("sb_six1", 32'(p1_if.six), 32'(e.s1));
      check("sb_six2", 32'(p2_if.six), 32'(e.s2));
    end
  end

  task automatic tick_once(output bit fired);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    fired = frame;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n, output int frames);
    bit f;
    frames = 0;
    for (int i = 0; i < n; i++) begin
      tick_once(f);
      if (f) frames++;
    end
  endtask

  task automatic ticks_to_frame(input int limit, output int n);
    bit f;
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick_once(f);
      if (f) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n   = 1'b0;
    pad_rst = 1'b1;
    repeat (3) @(negedge clk);
    res_n   = 1'b1;
    pad_rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int fr, n;

    vecs[0] = '{PadNone, 12'h000, PadNone, 12'h000, 12'hFFF, 12'hFFF, 1'b0, 1'b0};
    vecs[1] = '{PadMd3,  12'h041, PadNone, 12'h000, 12'hFBE, 12'hFFF, 1'b0, 1'b0};
    vecs[2] = '{PadNone, 12'h000, PadMd6,  12'h480, 12'hFFF, 12'hB7F, 1'b0, 1'b1};
    vecs[3] = '{PadMs,   12'h010, PadNone, 12'h000, 12'hFEF, 12'hFFF, 1'b0, 1'b0};
    vecs[4] = '{PadMd3,  12'h028, PadMd6,  12'h912, 12'hFD7, 12'h6ED, 1'b0, 1'b1};
    vecs[5] = '{PadMd6,  12'h000, PadMs,   12'h034, 12'hFFF, 12'hFCB, 1'b1, 1'b0};
    vecs[6] = '{PadMd3,  12'h0FF, PadMd6,  12'hFFF, 12'h000, 12'h000, 1'b1, 1'b1};

    // Reset values, pins all released.
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(joy_sel), 32'h1);
    check("rst_joy1", 32'(p1_if.joy), 32'hFFF);
    check("rst_joy2", 32'(p2_if.joy), 32'hFFF);
    check("rst_six", 32'({p1_if.six, p2_if.six}), 32'h0);
    check("rst_frame", 32'(frame), 32'h0);
    res_n   = 1'b1;
    pad_rst = 1'b0;
    ticks(300, fr);
    check("idle_joy1", 32'(p1_if.joy), 32'hFFF);
    check("idle_joy2", 32'(p2_if.joy), 32'hFFF);
    check("idle_frames", 32'(fr), 32'd2);

    // Vector table: one frame per pad combination, scored by the frame_o monitor.
    for (int v = 0; v < 7; v++) begin
      cfg1 = vecs[v].t1;
      btn1 = vecs[v].b1;
      cfg2 = vecs[v].t2;
      btn2 = vecs[v].b2;
      do_reset();
      exp_q.push_back(vecs[v]);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick_once(fr[0]);
      if (exp_q.size() > 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL vec%0d_timeout: got no frame_o, expected one within 20 ticks", v);
        exp_q.delete();
      end
    end

    // tick_i stalled mid-frame after phase 2: nothing may move.
    cfg1 = PadMd3;
    btn1 = 12'h041;
    cfg2 = PadNone;
    btn2 = 12'h000;
    do_reset();
    ticks(3, fr);
    check("pause_sel_before", 32'(joy_sel), 32'h0);
    check("pause_joy1_before", 32'(p1_if.joy), 32'hFFE);
    repeat (1000) @(negedge clk);
    check("pause_sel_after", 32'(joy_sel), 32'h0);
    check("pause_joy1_after", 32'(p1_if.joy), 32'hFFE);
    check("pause_joy2_after", 32'(p2_if.joy), 32'hFFF);
    ticks_to_frame(300, n);
    check("pause_ticks_to_frame", 32'(n), 32'd4);
    check("pause_joy1_frame", 32'(p1_if.joy), 32'hFBE);
    check("pause_six1", 32'(p1_if.six), 32'h0);
    ticks(256, fr);
    check("frames_per_256", 32'(fr), 32'd1);

    // Reset at phase 4 aborts the frame; polling restarts from phase 0.
    do_reset();
    ticks(4, fr);
    check("mid_joy1_pre", 32'(p1_if.joy), 32'hFBE);
    @(negedge clk);
    res_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(joy_sel), 32'h1);
    check("mid_rst_joy1", 32'(p1_if.joy), 32'hFFF);
    check("mid_rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    res_n = 1'b1;
    ticks_to_frame(300, n);
    check("mid_ticks_to_frame", 32'(n), 32'd7);
    check("mid_joy1_frame", 32'(p1_if.joy), 32'hFBE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sega_joy_reader.md
SEGA_JOY_READER -- requirements
Module: sega_joy_reader

Interface
REQ-001 SHALL have parameter PHASE_W, default 8, width of the phase counter; 2^PHASE_W ticks make one poll frame.
REQ-002 SHALL have port clk_sys  in  1  system clock; the single clock for all logic.
REQ-003 SHALL have port res_n_i  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port tick_i  in  1  one-cycle phase-advance strobe (one per video line).
REQ-005 SHALL have port joy1_pins_i  in  6  raw port-1 pins {p9,p6,right,left,down,up}, active-low, asynchronous.
REQ-006 SHALL have port joy2_pins_i  in  6  raw port-2 pins, same layout as joy1_pins_i.
REQ-007 SHALL have port joy_sel_o  out  1  shared select line to pin 7 of both ports.
REQ-008 SHALL have port joy1_o  out  12  port-1 buttons, active-low, {M,X,Y,Z,S,A,C,B,R,L,D,U}.
REQ-009 SHALL have port joy2_o  out  12  port-2 buttons, same format as joy1_o.
REQ-010 SHALL have port six1_o  out  1  port-1 six-button pad detected.
REQ-011 SHALL have port six2_o  out  1  port-2 six-button pad detected.
REQ-012 SHALL have port frame_o  out  1  one-cycle pulse when a poll frame completes (phase 6 executed).

Function
REQ-013 SHALL pass every pin through a 2-FF synchroniser; all logic below uses only the synchronised values ("pins").
REQ-014 SHALL hold a PHASE_W-bit phase counter that increments by 1 on each tick_i and wraps from all-ones to 0; no tick_i means no state change.
REQ-015 On a tick_i with phase N, SHALL perform the action for N in that cycle; captures use pins settled under the select value driven after the previous tick_i.
REQ-016 Phase 0: sel <= 0. Phase 1: sel <= 1.
REQ-017 Phase 2: sets [3:0] <= {R,L,D,U}; [5:4] <= {p9,p6} (C,B); six flag <= 0; sel <= 0.
REQ-018 Phase 3, per port: if R=0 and L=0 (Mega Drive pad), sets [7:6] <= {p9,p6} (Start,A); otherwise sets [7:4] <= {1,1,p9,p6} (Master System). Then sel <= 1.
REQ-019 Phase 4: sel <= 0.
REQ-020 Phase 5, per port: if R, L, D and U are all 0, six flag <= 1. Then sel <= 1.
REQ-021 Phase 6, per port: if six flag (registered value) = 1, sets [11:8] <= {R,L,D,U} (M,X,Y,Z), else [11:8] unchanged. Then sel <= 0; frame_o pulses high for that cycle.
REQ-022 Phases 7 to 2^PHASE_W-1: sel <= 1, no capture; this idle run SHALL give the six-button pad's internal counter time to reset.
REQ-023 Ports SHALL be decoded independently; one port's pad type SHALL never affect the other's bits.
REQ-024 Output bits not written in a phase SHALL hold their value.
REQ-025 six1_o/six2_o SHALL reflect the flags; a flag is cleared at phase 2 and may set again at phase 5 of the same frame.
REQ-026 When no pad is present (pins pulled high), all bits SHALL read 1 after one frame, and both six flags SHALL read 0.

Reset
REQ-027 res_n_i low SHALL asynchronously force: phase 0, sel 1, joy1_o/joy2_o 12'hFFF, six flags 0, frame_o 0, synchroniser stages 1.
REQ-028 Reset mid-frame SHALL abort the frame; after release, polling restarts at phase 0 on the next tick_i.

Structure
REQ-029 Package sega_joy_pkg SHALL hold: phase constants (PH_SEL0..PH_SIX = 0..6), bit-index constants for U..M, and JOY_RELEASED = 12'hFFF.
REQ-030 Synchroniser SHALL be one sub-module, joy_sync (2-FF, width parameter, reset value 1), instantiated once for the 12 pins.

Verification
REQ-031 Stimulus: reset asserted with pins all 1. Required: sel=1, joy1_o=joy2_o=FFF, six flags 0, and still FFF after 300 ticks.
REQ-032 Stimulus: 3-button pad model on port 1 holding A and Up. Required: after one frame, joy1_o=12'hFBE, six1_o=0, frame_o pulses exactly once per 256 ticks.
REQ-033 Stimulus: 6-button pad model on port 2 holding X and Start. Required: six2_o=1, joy2_o=12'hB7F, and joy1_o unaffected.
REQ-034 Stimulus: Master System pad on port 1 holding button 1 (p6). Required: joy1_o=12'hFEF, bits [7:6]=11.
REQ-035 Stimulus: res_n_i pulsed low at phase 4. Required: outputs return to reset values at once; next frame_o arrives exactly 7 ticks after release.
REQ-036 Stimulus: tick_i held low for 1000 cycles. Required: phase, sel and outputs all unchanged.
